param_fir_mac: RTL and testbench
================================

# param_fir_mac

Parametrised, time-multiplexed FIR filter with double-buffered coefficient RAM. Each accepted sample strobe shifts a new signed input into a TAPS-deep delay line. A single multiplier then accumulates one tap per clock, and the block outputs one rounded, scaled result per sample. Coefficients are written into a shadow bank while the filter runs. A swap request moves the shadow bank into service, but only on a sample boundary. The block sits between the 600 kHz sample-enable divider and the downstream output register stage.

## Interface
- TAPS, 11, number of taps; TAPS+2 ≤ sample period in clocks (20)
- IN_W, 3, signed input width
- COEF_W, 16, signed coefficient width
- OUT_W, 16, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before output
- ADDR_W, 6, coefficient address width; 2^ADDR_W ≥ TAPS
- iClk12M  in  1  system clock, 12 MHz
- iRst  in  1  reset; one clock, reset is synchronous and active-high
- iEnSample600k  in  1  sample strobe, one-cycle pulse
- iFirIn  in  IN_W  signed input sample, sampled on an accepted strobe
- iCoeffSwap  in  1  pulse: request a shadow/active bank swap
- iCsnRam  in  1  coefficient RAM chip select, active low
- iWrnRam  in  1  write enable, active low (high = read)
- iAddrRam  in  ADDR_W  tap index
- iWtDtRam  in  COEF_W  write data
- oRdDtRam  out  COEF_W  shadow-bank readback data
- oFirOut  out  OUT_W  filter output, held between samples
- oValid  out  1  one-cycle pulse when oFirOut updates
- oBusy  out  1  high while the FSM is not IDLE
- oSwapPending  out  1  a swap request is waiting for a sample boundary
- oOverrun  out  1  sticky: a strobe arrived while busy

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE → MAC on iEnSample600k. On that edge:
  - the delay line shifts (x[0] ← iFirIn, x[k] ← x[k-1]);
  - a pending swap is applied and oSwapPending clears;
  - the accumulator clears and the tap index is set to 0.
- MAC: each cycle computes acc += x[k]·c_active[k], k = 0..TAPS-1. Moves to OUT after k = TAPS-1.
- OUT: oFirOut ← scale(acc) and oValid ← 1 for one cycle, then → IDLE.
- Arithmetic:
  - full-precision signed product, width IN_W+COEF_W;
  - accumulator width IN_W+COEF_W+clog2(TAPS), so it never overflows;
  - scale = acc >>> SHIFT, then reduced to OUT_W (see Configuration).
- RAM write: iCsnRam=0 and iWrnRam=0 writes iWtDtRam to shadow[iAddrRam]. Writes with iAddrRam ≥ TAPS are ignored.
- RAM read: iCsnRam=0 and iWrnRam=1 gives oRdDtRam ← shadow[iAddrRam]. Addresses ≥ TAPS return 0. oRdDtRam holds its value when not reading.
- The active bank is never CPU-writable. Coefficients change only between samples.
- Swap request (iCoeffSwap=1) sets the pending flag. Multiple requests before the boundary collapse into one swap.
- A strobe while the FSM is in MAC or OUT is dropped (the delay line is not shifted) and oOverrun is set. oOverrun clears only on reset.
- A write in the same cycle as the applied swap lands in the pre-swap shadow bank, which becomes the active bank. The new shadow bank holds the old active coefficients.
- A strobe and iCoeffSwap in the same IDLE cycle: the swap is applied for this sample.

## Timing
- Reset values:
  - oFirOut = 0, oValid = 0, oBusy = 0, oSwapPending = 0, oOverrun = 0, oRdDtRam = 0;
  - delay line = 0, both coefficient banks = 0, FSM in IDLE.
- Strobe accepted at edge T:
  - MAC cycles T+1..T+TAPS;
  - OUT at T+TAPS+1;
  - oValid=1 and new oFirOut visible in cycle T+TAPS+2.
  - Latency is TAPS+2 clocks (13 for default TAPS).
- oBusy is high from T+1 through the OUT cycle.
- RAM read latency: 1 clock.
- Reset mid-MAC aborts the computation. No oValid is produced and all state returns to reset values.

## Configuration
- FIR_SAT_EN defined: a scaled result outside the OUT_W signed range saturates to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- FIR_SAT_EN undefined: the low OUT_W bits are taken (two's-complement wrap).

## Structure
- Package param_fir_pkg holds:
  - the FSM state typedef;
  - a clog2 helper function;
  - the accumulator-width localparam formula;
  - the saturate/truncate function.
- One sub-module, fir_coef_bank: both banks, the bank-select bit, write/read ports, and the swap-apply input.
- Delay line, FSM and MAC stay in the top module.

## Test plan
- **Impulse response.** Write shadow 0..10 = 12, 0, 19, 23, 0, 36, 48, 0, 101, 205, -13, then swap. Feed iFirIn=3'b001 for one sample, then 0. Successive oFirOut = 12, 0, 19, 23, 0, 36, 48, 0, 101, 205, 16'hFFF3, then 0. Each oValid arrives 13 clocks after its strobe.
- **Negative input.** Same coefficients, iFirIn=3'b100 (-4) as an impulse. First outputs are -48, 0, -76.
- **Saturation.** All coefficients 16'h7FFF, iFirIn=3'b011 held for 11 samples. Output is 16'h7FFF with FIR_SAT_EN, 16'h7FDF without.
- **Bank swap.**
  - Rewrite the shadow bank mid-stream; outputs are unchanged until iCoeffSwap is given.
  - A swap issued during MAC holds oSwapPending=1 and takes effect at the next strobe.
  - Readback of the shadow bank after the swap returns the old coefficients.
- **Overrun.** A second strobe 5 clocks after the first is ignored: no delay-line shift, oOverrun=1 and stays 1.
- **Reset mid-operation.** Assert iRst at MAC cycle 4. The next cycle shows all outputs 0, oValid never pulses, and both banks read back as 0.

Source files
------------

// File: rtl/param_fir_pkg.sv
// -----------------------------------------------------------------------------
// param_fir_pkg
// Shared types and helpers for the param_fir_mac FIR filter:
//   - fir_state_e : FSM state encoding (IDLE, MAC, OUT)
//   - clog2       : ceiling log2 usable in constant expressions
//   - fir_acc_w   : accumulator width formula, wide enough that a full sum of
//                   TAPS maximum-magnitude products never overflows
//   - fir_reduce  : reduces a scaled accumulator to OUT_W bits
// Build option: FIR_SAT_EN
//   defined   -> out-of-range results saturate to the OUT_W signed limits
//   undefined -> the low OUT_W bits are kept (two's-complement wrap)
// -----------------------------------------------------------------------------
package param_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Width of the generic reduction path; must cover any accumulator width.
  localparam int RED_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int fir_acc_w(input int in_w, input int coef_w, input int taps);
    return in_w + coef_w + clog2(taps);
  endfunction

  // Result is a sign-extended value already inside the OUT_W signed range, so
  // the caller can simply keep the low OUT_W bits.
  function automatic logic signed [RED_W-1:0] fir_reduce(
    input logic signed [RED_W-1:0] value,
    input int                      out_w
  );
`ifdef FIR_SAT_EN
    logic signed [RED_W-1:0] hi;
    logic signed [RED_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
`else
    // Keep the low out_w bits and sign-extend them back to full width.
    return (value <<< (RED_W - out_w)) >>> (RED_W - out_w);
`endif
  endfunction

endpackage

// File: rtl/param_fir_mac_if.sv
// -----------------------------------------------------------------------------
// param_fir_mac_if
// Sample/coefficient-RAM bus of param_fir_mac. Clock and reset stay outside.
//   iEnSample600k  sample strobe          iFirIn    signed input sample
//   iCoeffSwap     bank swap request      iCsnRam   RAM select (active low)
//   iWrnRam        write enable (low)     iAddrRam  tap index
//   iWtDtRam       write data             oRdDtRam  shadow-bank read data
//   oFirOut        filter output          oValid    output update pulse
//   oBusy          FSM not idle           oSwapPending  swap waiting
//   oOverrun       sticky dropped-strobe flag
// Modports: master (sample source / CPU side), slave (the filter).
// -----------------------------------------------------------------------------
interface param_fir_mac_if #(
  parameter int IN_W   = 3,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 6
);
  logic              iEnSample600k;
  logic [IN_W-1:0]   iFirIn;
  logic              iCoeffSwap;
  logic              iCsnRam;
  logic              iWrnRam;
  logic [ADDR_W-1:0] iAddrRam;
  logic [COEF_W-1:0] iWtDtRam;
  logic [COEF_W-1:0] oRdDtRam;
  logic [OUT_W-1:0]  oFirOut;
  logic              oValid;
  logic              oBusy;
  logic              oSwapPending;
  logic              oOverrun;

  modport master (
    output iEnSample600k, iFirIn, iCoeffSwap, iCsnRam, iWrnRam, iAddrRam, iWtDtRam,
    input  oRdDtRam, oFirOut, oValid, oBusy, oSwapPending, oOverrun
  );

  modport slave (
    input  iEnSample600k, iFirIn, iCoeffSwap, iCsnRam, iWrnRam, iAddrRam, iWtDtRam,
    output oRdDtRam, oFirOut, oValid, oBusy, oSwapPending, oOverrun
  );
endinterface

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// Double-buffered coefficient store. One bank is active (read by the MAC),
// the other is the shadow bank (CPU read/write). swap_apply_i flips roles.
//   clk_i, rst_i     clock, synchronous active-high reset
//   swap_apply_i     exchange shadow and active banks at this edge
//   cs_n_i, wr_n_i   RAM select / write enable, both active low
//   addr_i, wdata_i  shadow-bank address and write data
//   rdata_o          registered shadow-bank read data (holds when idle)
//   mac_idx_i        tap index for the active bank
//   mac_coef_o       combinational active-bank coefficient
// -----------------------------------------------------------------------------
module fir_coef_bank #(
  parameter int TAPS   = 11,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 6,
  parameter int TAP_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              swap_apply_i,
  input  logic              cs_n_i,
  input  logic              wr_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [COEF_W-1:0] wdata_i,
  output logic [COEF_W-1:0] rdata_o,
  input  logic [TAP_W-1:0]  mac_idx_i,
  output logic [COEF_W-1:0] mac_coef_o
);

  logic [COEF_W-1:0] bank_q [2][TAPS];
  logic              sel_q;      // index of the active bank
  logic [COEF_W-1:0] rdata_q;
  logic              shadow_sel;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic [TAP_W-1:0]  idx;

  assign shadow_sel = ~sel_q;
  assign in_range   = ({1'b0, addr_i} < (ADDR_W + 1)'(TAPS));
  assign wr_en      = !cs_n_i && !wr_n_i && in_range;
  assign rd_en      = !cs_n_i && wr_n_i;
  assign idx        = addr_i[TAP_W-1:0];

  // NOTE: non-blocking assignments let the write and the swap both see the
  // pre-edge sel_q, so a write coinciding with a swap lands in the bank that
  // becomes active.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the banks are reset explicitly because their contents are
      // observable right after reset; this keeps them in flops, not a RAM macro.
      bank_q  <= '{default: '0};
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (wr_en)        bank_q[shadow_sel][idx] <= wdata_i;
      if (swap_apply_i) sel_q <= ~sel_q;
      if (rd_en)        rdata_q <= in_range ? bank_q[shadow_sel][idx] : '0;
    end
  end

  assign rdata_o    = rdata_q;
  assign mac_coef_o = bank_q[sel_q][mac_idx_i];

endmodule

// File: rtl/param_fir_mac.sv
// -----------------------------------------------------------------------------
// param_fir_mac
// Time-multiplexed FIR filter: each accepted strobe shifts a sample into a
// TAPS-deep delay line, then one multiplier accumulates one tap per clock and
// the scaled result is registered on oFirOut with a one-cycle oValid.
// Latency from accepted strobe edge to visible oValid is TAPS+2 clocks.
// Ports:
//   iClk12M   system clock
//   iRst      synchronous active-high reset
//   bus       param_fir_mac_if.slave (sample, swap and coefficient RAM bus)
// Build option: FIR_SAT_EN selects saturation instead of wrap on the output.
// -----------------------------------------------------------------------------
module param_fir_mac
  import param_fir_pkg::*;
#(
  parameter int TAPS   = 11,
  parameter int IN_W   = 3,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = 6
) (
  input logic            iClk12M,
  input logic            iRst,
  param_fir_mac_if.slave bus
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W  = fir_acc_w(IN_W, COEF_W, TAPS);
  localparam int TAP_W  = (clog2(TAPS) < 1) ? 1 : clog2(TAPS);

  fir_state_e              state_q, state_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [IN_W-1:0]  x_q [TAPS];
  logic signed [IN_W-1:0]  x_d [TAPS];
  logic [OUT_W-1:0]        fir_out_q, fir_out_d;
  logic                    valid_q, valid_d;
  logic                    pend_q, pend_d;
  logic                    ovr_q, ovr_d;
  logic                    swap_apply;
  logic                    strobe;
  logic [COEF_W-1:0]       mac_coef;
  logic signed [PROD_W-1:0] prod;

  assign strobe = bus.iEnSample600k;

  fir_coef_bank #(
    .TAPS  (TAPS),
    .COEF_W(COEF_W),
    .ADDR_W(ADDR_W),
    .TAP_W (TAP_W)
  ) u_coef_bank (
    .clk_i       (iClk12M),
    .rst_i       (iRst),
    .swap_apply_i(swap_apply),
    .cs_n_i      (bus.iCsnRam),
    .wr_n_i      (bus.iWrnRam),
    .addr_i      (bus.iAddrRam),
    .wdata_i     (bus.iWtDtRam),
    .rdata_o     (bus.oRdDtRam),
    .mac_idx_i   (tap_q),
    .mac_coef_o  (mac_coef)
  );

  // Full-precision signed product of the current tap.
  assign prod = PROD_W'(x_q[tap_q]) * PROD_W'($signed(mac_coef));

  // NOTE: every variable gets a default before the case statement so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    acc_d      = acc_q;
    x_d        = x_q;
    fir_out_d  = fir_out_q;
    valid_d    = 1'b0;
    pend_d     = pend_q | bus.iCoeffSwap;
    ovr_d      = ovr_q;
    swap_apply = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          x_d[0] = $signed(bus.iFirIn);
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          // A request arriving with the strobe is honoured for this sample.
          swap_apply = pend_q | bus.iCoeffSwap;
          pend_d     = 1'b0;
          acc_d      = '0;
          tap_d      = '0;
          state_d    = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (tap_q == TAP_W'(TAPS - 1)) state_d = ST_OUT;
        else                           tap_d   = tap_q + 1'b1;
        if (strobe) ovr_d = 1'b1;
      end
      ST_OUT: begin
        fir_out_d = OUT_W'(fir_reduce(RED_W'(acc_q >>> SHIFT), OUT_W));
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
        if (strobe) ovr_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      tap_q     <= '0;
      acc_q     <= '0;
      x_q       <= '{default: '0};
      fir_out_q <= '0;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      fir_out_q <= fir_out_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.oFirOut      = fir_out_q;
  assign bus.oValid       = valid_q;
  assign bus.oBusy        = (state_q != ST_IDLE);
  assign bus.oSwapPending = pend_q;
  assign bus.oOverrun     = ovr_q;

endmodule

// File: tb/tb_param_fir_mac.sv
// -----------------------------------------------------------------------------
// tb_param_fir_mac
// Directed bench for param_fir_mac with default parameters: reset values,
// impulse responses, overrun, bank swapping, output reduction and reset
// during a computation. Expected values are hand-derived tables/constants.
// -----------------------------------------------------------------------------
module tb_param_fir_mac;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  param_fir_mac_if bus ();

  param_fir_mac dut (
    .iClk12M(clk),
    .iRst   (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] coef_c [11] = '{16'd12, 16'd0, 16'd19, 16'd23, 16'd0, 16'd36,
                               16'd48, 16'd0, 16'd101, 16'd205, 16'hFFF3};
  // -4 * coef_c[k], two's complement 16 bit.
  logic [15:0] neg_c  [11] = '{16'hFFD0, 16'h0000, 16'hFFB4, 16'hFFA4, 16'h0000,
                               16'hFF70, 16'hFF40, 16'h0000, 16'hFE6C, 16'hFCCC,
                               16'h0034};

`ifdef FIR_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h7FDF;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ram_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.iCsnRam  = 1'b0;
    bus.iWrnRam  = 1'b0;
    bus.iAddrRam = a;
    bus.iWtDtRam = d;
    @(negedge clk);
    bus.iCsnRam  = 1'b1;
    bus.iWrnRam  = 1'b1;
  endtask

  task automatic ram_read(input logic [5:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.iCsnRam  = 1'b0;
    bus.iWrnRam  = 1'b1;
    bus.iAddrRam = a;
    @(negedge clk);
    bus.iCsnRam  = 1'b1;
    d = bus.oRdDtRam;
  endtask

  task automatic swap_pulse();
    @(negedge clk);
    bus.iCoeffSwap = 1'b1;
    @(negedge clk);
    bus.iCoeffSwap = 1'b0;
  endtask

  // One sample: strobe, optional swap request swap_at clocks in, wait for
  // oValid (bounded), check latency and that oValid is a single pulse.
  task automatic run_sample(input logic [2:0] x, input int swap_at, output logic [15:0] y);
    int lat;
    @(negedge clk);
    bus.iEnSample600k = 1'b1;
    bus.iFirIn        = x;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.iEnSample600k = 1'b0;
      bus.iCoeffSwap    = (lat == swap_at);
      if (swap_at > 0 && lat == swap_at + 1)
        check("swap_pending_in_mac", bus.oSwapPending, 1);
      if (bus.oValid) break;
    end
    y = bus.oFirOut;
    check("latency", lat, 13);
    @(negedge clk);
    check("valid_pulse", bus.oValid, 0);
  endtask

  initial begin
    logic [15:0] y;
    logic [15:0] d;
    int          vcnt;
    logic        seen;

    rst               = 1'b1;
    bus.iEnSample600k = 1'b0;
    bus.iFirIn        = '0;
    bus.iCoeffSwap    = 1'b0;
    bus.iCsnRam       = 1'b1;
    bus.iWrnRam       = 1'b1;
    bus.iAddrRam      = '0;
    bus.iWtDtRam      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_out",     bus.oFirOut, 0);
    check("rst_valid",   bus.oValid, 0);
    check("rst_busy",    bus.oBusy, 0);
    check("rst_pending", bus.oSwapPending, 0);
    check("rst_overrun", bus.oOverrun, 0);
    check("rst_rdata",   bus.oRdDtRam, 0);

    // Load shadow bank, out-of-range write/read, readback, swap request
    for (int i = 0; i < 11; i++) ram_write(6'(i), coef_c[i]);
    ram_write(6'd11, 16'h1234);
    ram_read(6'd11, d); check("rd_out_of_range", d, 0);
    ram_read(6'd2, d);  check("rd_shadow2", d, 16'd19);
    ram_read(6'd10, d); check("rd_shadow10", d, 16'hFFF3);
    swap_pulse();
    check("pending_idle", bus.oSwapPending, 1);

    // Impulse response
    for (int s = 0; s < 12; s++) begin
      run_sample((s == 0) ? 3'b001 : 3'b000, -1, y);
      check($sformatf("impulse[%0d]", s), y, (s < 11) ? coef_c[s] : 16'h0000);
      if (s == 0) check("pending_applied", bus.oSwapPending, 0);
    end

    // Negative impulse, flushed out again by the last sample
    for (int s = 0; s < 12; s++) begin
      run_sample((s == 0) ? 3'b100 : 3'b000, -1, y);
      check($sformatf("neg_impulse[%0d]", s), y, (s < 11) ? neg_c[s] : 16'h0000);
    end

    // Overrun: second strobe 5 clocks after the first is dropped
    check("overrun_before", bus.oOverrun, 0);
    @(negedge clk);
    bus.iEnSample600k = 1'b1;
    bus.iFirIn        = 3'b001;
    @(negedge clk);
    bus.iEnSample600k = 1'b0;
    bus.iFirIn        = 3'b000;
    repeat (4) @(negedge clk);
    bus.iEnSample600k = 1'b1;
    bus.iFirIn        = 3'b001;
    @(negedge clk);
    bus.iEnSample600k = 1'b0;
    bus.iFirIn        = 3'b000;
    check("overrun_set", bus.oOverrun, 1);
    check("overrun_busy", bus.oBusy, 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.oValid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("overrun_valid_seen", seen, 1);
    check("overrun_out", bus.oFirOut, 16'd12);
    run_sample(3'b000, -1, y);
    check("overrun_no_shift", y, 16'd0);
    check("overrun_sticky", bus.oOverrun, 1);
    for (int s = 0; s < 10; s++) run_sample(3'b000, -1, y);

    // Bank swap: rewrite shadow mid-stream, swap during MAC
    for (int i = 0; i < 11; i++) ram_write(6'(i), 16'(100 + i));
    run_sample(3'b001, -1, y); check("old_bank_tap0", y, 16'd12);
    run_sample(3'b000, -1, y); check("old_bank_tap1", y, 16'd0);
    run_sample(3'b000, 4, y);  check("old_bank_tap2", y, 16'd19);
    check("pending_held", bus.oSwapPending, 1);
    run_sample(3'b000, -1, y); check("new_bank_tap3", y, 16'd103);
    check("pending_cleared", bus.oSwapPending, 0);
    ram_read(6'd0, d);  check("rd_old_active0", d, 16'd12);
    ram_read(6'd9, d);  check("rd_old_active9", d, 16'd205);
    ram_read(6'd10, d); check("rd_old_active10", d, 16'hFFF3);

    // Output reduction with full-scale coefficients
    for (int i = 0; i < 11; i++) ram_write(6'(i), 16'h7FFF);
    swap_pulse();
    for (int s = 0; s < 11; s++) run_sample(3'b011, -1, y);
    check("saturation", y, SAT_EXP);

    // Reset during MAC cycle 4
    @(negedge clk);
    bus.iEnSample600k = 1'b1;
    bus.iFirIn        = 3'b000;
    @(negedge clk);
    bus.iEnSample600k = 1'b0;
    bus.iCoeffSwap    = 1'b1;
    @(negedge clk);
    bus.iCoeffSwap    = 1'b0;
    repeat (1) @(negedge clk);
    check("pre_rst_busy", bus.oBusy, 1);
    check("pre_rst_pending", bus.oSwapPending, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out",     bus.oFirOut, 0);
    check("mid_rst_valid",   bus.oValid, 0);
    check("mid_rst_busy",    bus.oBusy, 0);
    check("mid_rst_pending", bus.oSwapPending, 0);
    check("mid_rst_overrun", bus.oOverrun, 0);
    check("mid_rst_rdata",   bus.oRdDtRam, 0);
    vcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.oValid) vcnt++;
    end
    check("no_valid_after_rst", vcnt, 0);
    ram_read(6'd0, d); check("shadow_cleared0", d, 0);
    ram_read(6'd5, d); check("shadow_cleared5", d, 0);
    swap_pulse();
    run_sample(3'b001, -1, y); check("active_cleared_out", y, 0);
    ram_read(6'd0, d); check("old_active_cleared0", d, 0);
    ram_read(6'd8, d); check("old_active_cleared8", d, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
